// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round controller.
package mole_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_ACTIVE,
        S_GAP,
        S_OVER
    } mole_state_e;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned SCORE_W = 8;
    localparam int unsigned MISS_W  = 2;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; reloads its seed on reset.
module lfsr16
    import mole_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= seed;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole round controller: spawns one mole at a pseudo-random hole,
// judges switch edges against it, tracks score/misses and ends the game.
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int unsigned N_HOLES      = 18,
    parameter logic [15:0] SEED         = 16'd483,
    parameter int unsigned TIMEOUT_INIT = 50_000_000,
    parameter int unsigned TIMEOUT_MIN  = 10_000_000,
    parameter int unsigned TIMEOUT_STEP = 2_000_000,
    parameter int unsigned GAP_CYCLES   = 12_500_000,
    parameter int unsigned MAX_MISSES   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_HOLES-1:0] sw_edge,
    output logic [N_HOLES-1:0] mole_leds,
    output logic               mole_hit,
    output logic [SCORE_W-1:0] score,
    output logic [MISS_W-1:0]  misses,
    output logic               game_over
);

    localparam int unsigned CW      = $clog2(TIMEOUT_INIT + 1);
    localparam int unsigned GW      = $clog2(GAP_CYCLES + 1);
    // One extra code so the "no previous hole" sentinel never matches a real hole
    localparam int unsigned IW      = $clog2(N_HOLES + 1);
    localparam int unsigned WIN_LIM = TIMEOUT_MIN + TIMEOUT_STEP;
    localparam logic [N_HOLES-1:0] LED_ONE = N_HOLES'(1);

    mole_state_e        state, state_nxt;
    logic [15:0]        lfsr_q;
    logic [IW-1:0]      raw_idx, spawn_idx, prev_idx, prev_idx_nxt;
    logic [CW-1:0]      cnt, cnt_nxt, window, window_nxt;
    logic [GW-1:0]      gap_cnt, gap_cnt_nxt;
    logic [N_HOLES-1:0] leds_nxt;
    logic               hit_nxt;
    logic [SCORE_W-1:0] score_nxt;
    logic [MISS_W-1:0]  misses_nxt, misses_inc;
    logic               correct, wrong, expire, out_of_lives;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (SEED),
        .q     (lfsr_q)
    );

    assign raw_idx = IW'(lfsr_q % 16'(N_HOLES));

    always_comb begin
        spawn_idx = raw_idx;
        if (raw_idx == prev_idx) begin
            spawn_idx = (raw_idx == IW'(N_HOLES - 1)) ? '0 : raw_idx + IW'(1);
        end
    end

    // The lit LED bus is the one-hot hole, so it doubles as the hit mask
    assign correct      = |(sw_edge & mole_leds);
    assign wrong        = |(sw_edge & ~mole_leds);
    assign expire       = (cnt == CW'(1));
    assign misses_inc   = misses + MISS_W'(1);
    assign out_of_lives = (32'(misses_inc) >= MAX_MISSES);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        gap_cnt_nxt  = gap_cnt;
        window_nxt   = window;
        prev_idx_nxt = prev_idx;
        leds_nxt     = mole_leds;
        hit_nxt      = 1'b0;
        score_nxt    = score;
        misses_nxt   = misses;

        unique case (state)
            S_IDLE, S_OVER: begin
                leds_nxt = '0;
                if (start) begin
                    score_nxt  = '0;
                    misses_nxt = '0;
                    window_nxt = CW'(TIMEOUT_INIT);
                    state_nxt  = S_SPAWN;
                end
            end
            S_SPAWN: begin
                prev_idx_nxt = spawn_idx;
                leds_nxt     = LED_ONE << spawn_idx;
                cnt_nxt      = window;
                state_nxt    = S_ACTIVE;
            end
            S_ACTIVE: begin
                cnt_nxt = cnt - CW'(1);
                if (correct) begin
                    hit_nxt     = 1'b1;
                    score_nxt   = (score == '1) ? score : score + SCORE_W'(1);
                    // compare first so the subtraction can never wrap
                    window_nxt  = (32'(window) < WIN_LIM) ? CW'(TIMEOUT_MIN)
                                                          : window - CW'(TIMEOUT_STEP);
                    leds_nxt    = '0;
                    gap_cnt_nxt = GW'(GAP_CYCLES);
                    state_nxt   = S_GAP;
                end else if (wrong || expire) begin
                    misses_nxt = misses_inc;
                    if (out_of_lives) begin
                        leds_nxt  = '0;
                        state_nxt = S_OVER;
                    end else if (expire) begin
                        leds_nxt    = '0;
                        gap_cnt_nxt = GW'(GAP_CYCLES);
                        state_nxt   = S_GAP;
                    end
                end
            end
            S_GAP: begin
                leds_nxt    = '0;
                gap_cnt_nxt = gap_cnt - GW'(1);
                if (gap_cnt == GW'(1)) begin
                    state_nxt = S_SPAWN;
                end
            end
            default: begin
                leds_nxt  = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            gap_cnt   <= '0;
            window    <= CW'(TIMEOUT_INIT);
            prev_idx  <= IW'(N_HOLES);
            mole_leds <= '0;
            mole_hit  <= 1'b0;
            score     <= '0;
            misses    <= '0;
            game_over <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            window    <= window_nxt;
            prev_idx  <= prev_idx_nxt;
            mole_leds <= leds_nxt;
            mole_hit  <= hit_nxt;
            score     <= score_nxt;
            misses    <= misses_nxt;
            game_over <= (state_nxt == S_OVER);
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// Scoreboard bench for mole_scheduler: per-cycle expectations are queued when
// stimulus is driven and compared when the registered outputs update.
module tb_mole_scheduler;

    localparam int N  = 18;
    localparam int TI = 20;
    localparam int TM = 8;
    localparam int TS = 5;
    localparam int GC = 3;
    localparam int MM = 3;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] sw_edge = '0;
    logic [N-1:0] mole_leds;
    logic         mole_hit;
    logic [7:0]   score;
    logic [1:0]   misses;
    logic         game_over;

    mole_scheduler #(
        .N_HOLES      (N),
        .SEED         (16'd483),
        .TIMEOUT_INIT (TI),
        .TIMEOUT_MIN  (TM),
        .TIMEOUT_STEP (TS),
        .GAP_CYCLES   (GC),
        .MAX_MISSES   (MM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sw_edge   (sw_edge),
        .mole_leds (mole_leds),
        .mole_hit  (mole_hit),
        .score     (score),
        .misses    (misses),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        string        name;
        logic [N-1:0] leds;
        logic         hit;
        logic [7:0]   score;
        logic [1:0]   misses;
        logic         over;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         m_prev = -1;
    int         cur_idx = 0;
    int         first_idx = 0;
    int         exp_win = TI;
    logic [7:0] exp_score = '0;
    logic [1:0] exp_misses = '0;
    logic       exp_over = 1'b0;
    logic [15:0] m_lfsr;

    // Reference LFSR, same reset and clock as the design
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'd483;
        else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (rst_n && exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            checks++;
            if ({mole_leds, mole_hit, score, misses, game_over} !==
                {mon_e.leds, mon_e.hit, mon_e.score, mon_e.misses, mon_e.over}) begin
                errors++;
                $display("FAIL %s cyc %0d: got leds %h hit %b score %0d misses %0d over %b, want leds %h hit %b score %0d misses %0d over %b",
                         mon_e.name, cyc, mole_leds, mole_hit, score, misses, game_over,
                         mon_e.leds, mon_e.hit, mon_e.score, mon_e.misses, mon_e.over);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [N-1:0] oh(int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int pick();
        int i;
        i = int'(m_lfsr % 16'(N));
        if (i == m_prev) i = (i + 1) % N;
        m_prev = i;
        return i;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_out(string nm, logic [N-1:0] leds, logic hit);
        exp_t e;
        e.cyc    = cyc + 1;
        e.name   = nm;
        e.leds   = leds;
        e.hit    = hit;
        e.score  = exp_score;
        e.misses = exp_misses;
        e.over   = exp_over;
        exp_q.push_back(e);
    endtask

    task automatic reset_dut(string nm);
        rst_n   = 1'b0;
        start   = 1'b0;
        sw_edge = '0;
        exp_q.delete();
        #2;
        checks++;
        if ({mole_leds, mole_hit, score, misses, game_over} !== 30'd0) begin
            errors++;
            $display("FAIL %s async: got outputs %h, want 0", nm,
                     {mole_leds, mole_hit, score, misses, game_over});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        m_prev     = -1;
        exp_score  = '0;
        exp_misses = '0;
        exp_over   = 1'b0;
        repeat (3) begin
            expect_out({nm, "_idle"}, '0, 1'b0);
            tick();
        end
    endtask

    task automatic spawn_tick(string nm);
        cur_idx = pick();
        expect_out({nm, "_spawn"}, oh(cur_idx), 1'b0);
        tick();
    endtask

    task automatic start_game(string nm);
        start      = 1'b1;
        exp_score  = '0;
        exp_misses = '0;
        exp_over   = 1'b0;
        exp_win    = TI;
        expect_out({nm, "_start"}, '0, 1'b0);
        tick();
        start = 1'b0;
        spawn_tick(nm);
    endtask

    task automatic gap_then_spawn(string nm);
        repeat (GC) begin
            expect_out({nm, "_gap"}, '0, 1'b0);
            tick();
        end
        spawn_tick(nm);
    endtask

    task automatic quiet(int n, string nm);
        repeat (n) begin
            expect_out({nm, "_lit"}, oh(cur_idx), 1'b0);
            tick();
        end
    endtask

    task automatic hit_mole(string nm, logic [N-1:0] extra);
        sw_edge = oh(cur_idx) | extra;
        if (exp_score != 8'hFF) exp_score = exp_score + 8'd1;
        exp_win = (exp_win - TS < TM) ? TM : exp_win - TS;
        expect_out({nm, "_hit"}, '0, 1'b1);
        tick();
        sw_edge = '0;
        gap_then_spawn(nm);
    endtask

    task automatic timeout_mole(string nm);
        quiet(exp_win - 1, nm);
        exp_misses = exp_misses + 2'd1;
        if (exp_misses == 2'(MM)) exp_over = 1'b1;
        expect_out({nm, "_expire"}, '0, 1'b0);
        tick();
        if (!exp_over) gap_then_spawn(nm);
    endtask

    task automatic wrong_switch(string nm);
        sw_edge = oh((cur_idx + 1) % N);
        exp_misses = exp_misses + 2'd1;
        if (exp_misses == 2'(MM)) begin
            exp_over = 1'b1;
            expect_out({nm, "_wrong"}, '0, 1'b0);
        end else begin
            expect_out({nm, "_wrong"}, oh(cur_idx), 1'b0);
        end
        tick();
        sw_edge = '0;
    endtask

    task automatic test_reset();
        reset_dut("reset");
    endtask

    task automatic test_start_hit();
        int old;
        start_game("start_hit");
        first_idx = cur_idx;
        quiet(4, "start_hit");
        old = cur_idx;
        hit_mole("start_hit", '0);
        checks++;
        if (mole_leds === oh(old)) begin
            errors++;
            $display("FAIL start_hit_newidx: got leds %h, want a hole other than %0d", mole_leds, old);
        end
        timeout_mole("win15");
    endtask

    task automatic test_timeout();
        reset_dut("timeout_rst");
        start_game("timeout");
        repeat (MM) timeout_mole("timeout");
        expect_out("over_hold", '0, 1'b0);
        tick();
        expect_out("over_hold", '0, 1'b0);
        tick();
        checks++;
        if (game_over !== 1'b1 || misses !== 2'(MM)) begin
            errors++;
            $display("FAIL over_state: got game_over %b misses %0d, want 1 and %0d", game_over, misses, MM);
        end
        start_game("restart");
        hit_mole("restart", '0);
    endtask

    task automatic test_wrong_then_hit();
        reset_dut("wrong_rst");
        start_game("wrong");
        quiet(2, "wrong");
        wrong_switch("wrong");
        quiet(1, "wrong");
        hit_mole("wrong", '0);
    endtask

    task automatic test_simultaneous();
        reset_dut("simul_rst");
        start_game("simul");
        hit_mole("simul_both", oh((cur_idx + 3) % N));
        quiet(exp_win - 1, "simul_exp");
        hit_mole("simul_exp", '0);
        // wrong switch landing on the expiry cycle costs one miss only
        quiet(exp_win - 1, "wrong_exp");
        sw_edge = oh((cur_idx + 1) % N);
        exp_misses = exp_misses + 2'd1;
        expect_out("wrong_exp_expire", '0, 1'b0);
        tick();
        sw_edge = '0;
        gap_then_spawn("wrong_exp");
    endtask

    task automatic test_window_floor();
        reset_dut("floor_rst");
        start_game("floor");
        hit_mole("floor", '0);
        hit_mole("floor", '0);
        timeout_mole("win10");
        hit_mole("floor", '0);
        hit_mole("floor", '0);
        timeout_mole("win8");
    endtask

    task automatic test_score_sat();
        reset_dut("sat_rst");
        start_game("sat");
        repeat (256) hit_mole("sat", '0);
        checks++;
        if (score !== 8'd255) begin
            errors++;
            $display("FAIL score_sat: got score %0d, want 255", score);
        end
    endtask

    task automatic test_reset_mid();
        reset_dut("mid_rst");
        start_game("mid");
        quiet(3, "mid");
        reset_dut("reset_mid");
        start_game("fresh");
        checks++;
        if (mole_leds !== oh(first_idx)) begin
            errors++;
            $display("FAIL fresh_idx: got leds %h, want %h", mole_leds, oh(first_idx));
        end
    endtask

    initial begin
        test_reset();
        test_start_hit();
        test_timeout();
        test_wrong_then_hit();
        test_simultaneous();
        test_window_floor();
        test_score_sat();
        test_reset_mid();
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Round controller for the whack-a-mole game. Picks a pseudo-random hole, lights exactly one mole on the LED bus for a bounded window, and judges switch edges against it. Tracks score and misses, shortens the window as the score rises, and ends the game after too many misses. Sits between the switch edge detector, which supplies one-cycle rising-edge pulses per switch, and the LED and hex display drivers.

## Interface
- `N_HOLES`, 18: number of holes and switches; range 2..18.
- `SEED`, 16'd483: LFSR reset value; must be nonzero.
- `TIMEOUT_INIT`, 50_000_000: initial mole window, in cycles.
- `TIMEOUT_MIN`, 10_000_000: floor for the window.
- `TIMEOUT_STEP`, 2_000_000: window reduction per hit.
- `GAP_CYCLES`, 12_500_000: dark interval between moles.
- `MAX_MISSES`, 3: misses that end the game.
- `clk` input 1: system clock.
- `rst_n` input 1: reset. One clock; `rst_n` is asynchronous and active-low.
- `start` input 1: level-sampled. Acted on only in IDLE or OVER.
- `sw_edge` input N_HOLES: one-cycle rising-edge pulses, one per switch.
- `mole_leds` output N_HOLES: one-hot position of the active mole, or zero.
- `mole_hit` output 1: one-cycle pulse on a correct hit.
- `score` output 8: hit count; saturates at 255.
- `misses` output 2: miss count.
- `game_over` output 1: high while in OVER.

## Operation
- Reset values:
  - State is IDLE.
  - `mole_leds`, `mole_hit`, `score`, `misses` and `game_over` are all 0.
  - The LFSR is loaded with `SEED`.
  - The window register is loaded with `TIMEOUT_INIT`.
- LFSR:
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle, including in IDLE, so player timing adds entropy.
- States:
  - IDLE: LEDs dark. On `start`: clear `score` and `misses`, set the window to `TIMEOUT_INIT`, go to SPAWN.
  - SPAWN (1 cycle):
    - Hole index = `lfsr % N_HOLES`.
    - If the index equals the previous index, use index+1, wrapping N_HOLES-1 to 0.
    - Set `mole_leds` one-hot at that index, load the down-counter with the window, go to ACTIVE.
  - ACTIVE: decrement the counter each cycle and judge `sw_edge`, in this priority order:
    1. Correct hit: `sw_edge[idx]` is set. Pulse `mole_hit`, increment `score` (saturating), reduce the window by `TIMEOUT_STEP` with a floor of `TIMEOUT_MIN`, clear the LEDs, go to GAP. Other bits set in the same cycle are ignored.
    2. Wrong switch: any other bit is set. Increment `misses`. Stay in ACTIVE with the mole still lit.
    3. Timeout: the counter reaches 0. Increment `misses`, clear the LEDs, go to GAP.
    - A hit on the same cycle as counter expiry counts as a hit.
    - A wrong switch on the expiry cycle adds one miss only.
    - If `misses` reaches `MAX_MISSES`, clear the LEDs and go to OVER (this overrides GAP).
  - GAP: LEDs dark. Count `GAP_CYCLES`, then go to SPAWN. `sw_edge` is ignored.
  - OVER:
    - `game_over`=1, LEDs dark.
    - `score` and `misses` are held for display.
    - On `start`, restart exactly as from IDLE.
- Arithmetic:
  - The counter width is `$clog2(TIMEOUT_INIT+1)`.
  - Window update: if window − STEP < MIN then MIN, else window − STEP. Compare before subtracting so the result never underflows.

## Timing
- `start` sampled at cycle t: SPAWN at t+1; `mole_leds` nonzero at t+2.
- `sw_edge` hit at cycle t: `mole_hit`, new `score` and dark LEDs all visible at t+1.
- Window W: with no input, the mole is lit for exactly W cycles.
- GAP: the next mole lights exactly `GAP_CYCLES`+1 cycles after GAP entry (GAP plus SPAWN).
- All outputs are registered. No combinational path from inputs to outputs.
- `rst_n` asserted mid-game: immediate return to reset values, regardless of state.

## Structure
- Package `mole_pkg`:
  - State enum `mole_state_e`.
  - `LFSR_TAPS` constant (16'hB400).
  - Score and miss width constants.
- Sub-module `lfsr16`: ports `clk`, `rst_n`, `seed`, `q`. Free-running.
- Hole selection, counters and the FSM live in `mole_scheduler`.

## Test plan
All scenarios use TIMEOUT_INIT=20, TIMEOUT_MIN=8, TIMEOUT_STEP=5, GAP_CYCLES=3 and MAX_MISSES=3.

- Start and hit: pulse `start`, then pulse `sw_edge` at the lit index in window cycle 5. Expect `mole_hit`=1 for one cycle, `score`=1, next window 15, next mole lit 4 cycles later at a different index.
- Timeout: no input. Mole lit for exactly 20 cycles, then `misses`=1, `score`=0. After three timeouts expect `game_over`=1 and LEDs 0.
- Wrong switch, then hit: a wrong bit then the correct bit, in separate cycles. Expect `misses`=1, then a hit, `score`=1.
- Simultaneous events:
  - Correct and wrong bits in the same cycle: hit only, `misses` unchanged.
  - Hit on the counter-expiry cycle: counts as a hit.
- Window floor: three consecutive hits give windows 15, 10, 8. A fourth hit keeps 8. Score saturation is checked by forcing 255: it stays at 255.
- Reset mid-ACTIVE: drive `rst_n` low. All outputs are 0 asynchronously. After release: IDLE, and the LFSR restarts from 483, so the first index matches a fresh run.
